// File: rtl/controlador_contexto.sv
// controlador_contexto: RAM bus master that switches context between program 1 and 2.
// Saves PC + registers of the running program, toggles programa, restores the other one.
// Ports:
//   clock, reset (async, active-low); troca: switch request, sampled in IDLE
//   pc_atual: running PC; pc_out/pc_load: restored PC and its load pulse
//   ocupado/pronto: busy flag and completion pulse; programa: active program (1/2)
//   reg_sel/reg_rd_data/reg_wr_en/reg_wr_data: register file access
//   mem_we/mem_endereco_escrita/mem_data: RAM write port
//   mem_endereco_leitura/mem_q: RAM read port (1-cycle latency)
module controlador_contexto #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int NUM_REGS    = 32,
   parameter int BASE_STRIDE = 1000,
   parameter int CTX_OFFSET  = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  troca,
   input  logic [DATA_WIDTH-1:0] pc_atual,
   output logic                  ocupado,
   output logic                  pronto,
   output logic [1:0]            programa,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic                  pc_load,
   output logic [5:0]            reg_sel,
   input  logic [DATA_WIDTH-1:0] reg_rd_data,
   output logic                  reg_wr_en,
   output logic [DATA_WIDTH-1:0] reg_wr_data,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_endereco_escrita,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic [ADDR_WIDTH-1:0] mem_endereco_leitura,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   localparam int IW = $clog2(NUM_REGS + 2);

   typedef enum logic [2:0] {
      IDLE,
      SALVA,
      TROCA,
      LE,
      FIM
   } estado_t;

   estado_t         estado;
   estado_t         prox;
   logic [IW-1:0]   i;
   logic [ADDR_WIDTH-1:0] base;

   // Context area of the currently active program.
   assign base = ADDR_WIDTH'(programa) * ADDR_WIDTH'(BASE_STRIDE)
               + ADDR_WIDTH'(CTX_OFFSET);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado   <= IDLE;
         i        <= '0;
         programa <= 2'd1;
         pc_out   <= '0;
      end else begin
         estado <= prox;
         // index restarts on every state entry
         if (prox != estado || estado == IDLE)
            i <= '0;
         else
            i <= i + IW'(1);
         if (estado == TROCA)
            programa <= (programa == 2'd1) ? 2'd2 : 2'd1;
         // slot 0 (PC) was addressed at i=0, so it arrives at i=1
         if (estado == LE && i == IW'(1))
            pc_out <= mem_q;
      end
   end

   always_comb begin
      prox                 = estado;
      ocupado              = 1'b0;
      pronto               = 1'b0;
      pc_load              = 1'b0;
      reg_sel              = '0;
      reg_wr_en            = 1'b0;
      reg_wr_data          = '0;
      mem_we               = 1'b0;
      mem_endereco_escrita = '0;
      mem_data             = '0;
      mem_endereco_leitura = '0;
      unique case (estado)
         IDLE: begin
            if (troca)
               prox = SALVA;
         end
         SALVA: begin
            ocupado              = 1'b1;
            mem_we               = 1'b1;
            mem_endereco_escrita = base + ADDR_WIDTH'(i);
            if (i == '0) begin
               mem_data = pc_atual;
            end else begin
               reg_sel  = 6'(i - IW'(1));
               mem_data = reg_rd_data;
            end
            if (i == IW'(NUM_REGS))
               prox = TROCA;
         end
         TROCA: begin
            ocupado = 1'b1;
            prox    = LE;
         end
         LE: begin
            ocupado = 1'b1;
            if (i <= IW'(NUM_REGS))
               mem_endereco_leitura = base + ADDR_WIDTH'(i);
            // read data lags the address by one cycle: r(i-2) arrives now
            if (i >= IW'(2)) begin
               reg_wr_en   = 1'b1;
               reg_sel     = 6'(i - IW'(2));
               reg_wr_data = mem_q;
            end
            if (i == IW'(NUM_REGS + 1))
               prox = FIM;
         end
         FIM: begin
            ocupado = 1'b1;
            pronto  = 1'b1;
            pc_load = 1'b1;
            prox    = IDLE;
         end
         default: prox = IDLE;
      endcase
   end

endmodule

// File: tb/tb_controlador_contexto.sv
// tb_controlador_contexto: bench for controlador_contexto with RAM and register
// file models and a context-level reference model.
module tb_controlador_contexto;

   localparam int N   = 32;
   localparam int STR = 1000;
   localparam int LAT = 2 * N + 5;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        troca = 1'b0;
   logic [31:0] pc_atual = '0;
   logic        ocupado, pronto, pc_load, reg_wr_en, mem_we;
   logic [1:0]  programa;
   logic [31:0] pc_out, reg_rd_data, reg_wr_data, mem_data, mem_q;
   logic [31:0] mem_endereco_escrita, mem_endereco_leitura;
   logic [5:0]  reg_sel;

   logic [31:0] ram  [0:4095];
   logic [31:0] regs [0:63];

   // reference model: saved contexts and the running context
   logic [31:0] ctx_pc [1:2];
   logic [31:0] ctx_r  [1:2][0:N-1];
   logic [31:0] cur_pc;
   logic [31:0] cur_r  [0:N-1];
   int          prog_m = 1;

   int tests = 0;
   int fails = 0;
   int bad_both = 0, bad_idle = 0, bad_pl = 0, bad_addr = 0;

   typedef struct {
      logic [31:0] pc_in;
      logic [31:0] rbase;
      logic [31:0] opc;
      logic [31:0] orbase;
      logic [31:0] exp_pc;
      logic [1:0]  exp_prog;
   } vec_t;
   vec_t tbl [4];

   always #5 clock = ~clock;

   controlador_contexto #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(N),
      .BASE_STRIDE(STR), .CTX_OFFSET(0)
   ) dut (
      .clock(clock), .reset(reset), .troca(troca), .pc_atual(pc_atual),
      .ocupado(ocupado), .pronto(pronto), .programa(programa),
      .pc_out(pc_out), .pc_load(pc_load), .reg_sel(reg_sel),
      .reg_rd_data(reg_rd_data), .reg_wr_en(reg_wr_en),
      .reg_wr_data(reg_wr_data), .mem_we(mem_we),
      .mem_endereco_escrita(mem_endereco_escrita), .mem_data(mem_data),
      .mem_endereco_leitura(mem_endereco_leitura), .mem_q(mem_q)
   );

   assign reg_rd_data = regs[reg_sel];

   always @(posedge clock) begin
      mem_q <= ram[mem_endereco_leitura[11:0]];
      if (mem_we) ram[mem_endereco_escrita[11:0]] = mem_data;
      if (reg_wr_en) regs[reg_sel] = reg_wr_data;
   end

   always @(negedge clock) begin
      if (mem_we && reg_wr_en) bad_both++;
      if (!ocupado && (mem_we || reg_wr_en)) bad_idle++;
      if (pc_load != pronto) bad_pl++;
      if (mem_we && !((mem_endereco_escrita >= 32'd1000 && mem_endereco_escrita <= 32'd1032) ||
                      (mem_endereco_escrita >= 32'd2000 && mem_endereco_escrita <= 32'd2032)))
         bad_addr++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic set_cur(input logic [31:0] pc, input logic [31:0] rb, input bit rnd);
      cur_pc   = pc;
      pc_atual = pc;
      for (int k = 0; k < N; k++) begin
         cur_r[k] = rnd ? $urandom : rb + 32'(k);
         regs[k]  = cur_r[k];
      end
   endtask

   task automatic preload(input int p, input logic [31:0] pc, input logic [31:0] rb, input bit rnd);
      logic [31:0] v;
      ctx_pc[p]   = pc;
      ram[p * STR] = pc;
      for (int k = 0; k < N; k++) begin
         v = rnd ? $urandom : rb + 32'(k);
         ctx_r[p][k]        = v;
         ram[p * STR + 1 + k] = v;
      end
   endtask

   task automatic do_switch(input int busy_at);
      int old_p, new_p, lat, npr, nwe, nwr, bad;
      logic [1:0] prog_le;
      old_p = prog_m;
      new_p = 3 - prog_m;
      lat = -1; npr = 0; nwe = 0; nwr = 0; prog_le = 2'd0;
      @(negedge clock);
      troca = 1'b1;
      @(posedge clock);
      #1 troca = 1'b0;
      for (int c = 1; c <= LAT + 20; c++) begin
         @(negedge clock);
         troca = (c == busy_at);
         if (pronto) begin
            npr++;
            if (lat < 0) lat = c;
         end
         if (mem_we) nwe++;
         if (reg_wr_en) nwr++;
         if (c == N + 3) prog_le = programa;
      end
      troca = 1'b0;
      chk("latency", 32'(lat), 32'(LAT));
      chk("pronto_count", 32'(npr), 32'd1);
      chk("mem_we_cycles", 32'(nwe), 32'(N + 1));
      chk("reg_wr_cycles", 32'(nwr), 32'(N));
      chk("programa_in_le", 32'(prog_le), 32'(new_p));
      chk("programa_after", 32'(programa), 32'(new_p));
      chk("pc_out", pc_out, ctx_pc[new_p]);
      chk("idle_after", 32'(ocupado), 32'd0);
      bad = 0;
      if (ram[old_p * STR] !== cur_pc) bad++;
      for (int k = 0; k < N; k++)
         if (ram[old_p * STR + 1 + k] !== cur_r[k]) bad++;
      chk("save_area_errors", 32'(bad), 32'd0);
      bad = 0;
      for (int k = 0; k < N; k++)
         if (regs[k] !== ctx_r[new_p][k]) bad++;
      chk("restored_reg_errors", 32'(bad), 32'd0);
      ctx_pc[old_p] = cur_pc;
      for (int k = 0; k < N; k++) begin
         ctx_r[old_p][k] = cur_r[k];
         cur_r[k]        = ctx_r[new_p][k];
      end
      cur_pc   = ctx_pc[new_p];
      pc_atual = cur_pc;
      prog_m   = new_p;
   endtask

   initial begin
      logic [31:0] snap_pc;
      logic [31:0] snap_r [0:N-1];
      int nwe, bad;

      tbl[0] = '{32'h40,       32'h100,      32'h80,       32'h200,      32'h80,       2'd2};
      tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFF0, 32'h0,        32'h0,        32'h0,        2'd1};
      tbl[2] = '{32'h12345678, 32'hA5A50000, 32'hDEADBEEF, 32'h5A5A0000, 32'hDEADBEEF, 2'd2};
      tbl[3] = '{32'h4,        32'h0,        32'h1000,     32'h70000000, 32'h1000,     2'd1};

      for (int a = 0; a < 4096; a++) ram[a] = '0;
      for (int k = 0; k < 64; k++) regs[k] = '0;
      for (int p = 1; p <= 2; p++) begin
         ctx_pc[p] = '0;
         for (int k = 0; k < N; k++) ctx_r[p][k] = '0;
      end
      for (int k = 0; k < N; k++) cur_r[k] = '0;
      cur_pc = '0;

      // reset state
      repeat (3) @(negedge clock);
      chk("rst_programa", 32'(programa), 32'd1);
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_flags", 32'({ocupado, pronto, pc_load, mem_we, reg_wr_en}), 32'd0);
      chk("rst_reg_sel", 32'(reg_sel), 32'd0);
      chk("rst_waddr", mem_endereco_escrita, 32'd0);
      chk("rst_raddr", mem_endereco_leitura, 32'd0);
      chk("rst_data", mem_data | reg_wr_data, 32'd0);
      reset = 1'b1;
      nwe = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         if (mem_we || ocupado) nwe++;
      end
      chk("idle_no_activity", 32'(nwe), 32'd0);
      chk("idle_programa", 32'(programa), 32'd1);

      // table-driven switches
      for (int t = 0; t < 4; t++) begin
         set_cur(tbl[t].pc_in, tbl[t].rbase, 1'b0);
         preload(3 - prog_m, tbl[t].opc, tbl[t].orbase, 1'b0);
         do_switch(0);
         chk("tbl_pc_out", pc_out, tbl[t].exp_pc);
         chk("tbl_programa", 32'(programa), 32'(tbl[t].exp_prog));
      end

      // round trip from program 1
      set_cur(32'hC0DE0000, 32'h0, 1'b1);
      snap_pc = cur_pc;
      for (int k = 0; k < N; k++) snap_r[k] = cur_r[k];
      do_switch(0);
      do_switch(0);
      bad = 0;
      for (int k = 0; k < N; k++)
         if (regs[k] !== snap_r[k]) bad++;
      chk("roundtrip_regs", 32'(bad), 32'd0);
      chk("roundtrip_pc", pc_out, snap_pc);
      chk("roundtrip_programa", 32'(programa), 32'd1);

      // abort at cycle 20: slots 0..18 (PC, r0..r17) already written
      set_cur(32'h0BAD0000, 32'h0, 1'b1);
      @(negedge clock);
      troca = 1'b1;
      @(posedge clock);
      #1 troca = 1'b0;
      repeat (20) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("abort_ocupado", 32'(ocupado), 32'd0);
      chk("abort_programa", 32'(programa), 32'd1);
      chk("abort_mem_we", 32'(mem_we), 32'd0);
      ctx_pc[1] = cur_pc;
      for (int k = 0; k < 18; k++) ctx_r[1][k] = cur_r[k];
      prog_m = 1;
      repeat (5) @(negedge clock);
      bad = 0;
      if (ram[STR] !== ctx_pc[1]) bad++;
      for (int k = 0; k < N; k++)
         if (ram[STR + 1 + k] !== ctx_r[1][k]) bad++;
      chk("abort_partial_ram", 32'(bad), 32'd0);
      reset = 1'b1;
      repeat (10) @(negedge clock);
      chk("abort_idle_programa", 32'(programa), 32'd1);
      do_switch(0);

      // request while busy is ignored
      set_cur(32'h00001234, 32'h300, 1'b0);
      do_switch(10);

      // randomized switches
      for (int r = 0; r < 6; r++) begin
         set_cur($urandom, 32'h0, 1'b1);
         if ($urandom_range(1, 0) == 1)
            preload(3 - prog_m, $urandom, 32'h0, 1'b1);
         do_switch(0);
      end

      chk("never_both_strobes", 32'(bad_both), 32'd0);
      chk("no_write_when_idle", 32'(bad_idle), 32'd0);
      chk("pc_load_with_pronto", 32'(bad_pl), 32'd0);
      chk("write_addr_range", 32'(bad_addr), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
